seg_scan_driver: RTL and testbench

Parametrised multiplexed 7-segment scan driver for the watch and counter displays. Time-multiplexes `DIGITS` hex digits onto one shared segment bus with a dead-time gap between digits to prevent ghosting. Supports per-digit blink, blank and decimal point. Sits between the application's BCD/hex value registers and the board's segment/anode pins.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_if.sv | 15 +
 rtl/seg_decode.sv | 10 +
 rtl/seg_scan_driver.sv | 129 ++++++++++++
 tb/tb_seg_scan_driver.sv | 134 +++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg_pkg;

    typedef enum logic {GAP, SHOW} slot_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // {CA..CG}, active-low; entry 15 first so SEG_GLYPH[n] is hex digit n
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

endpackage

// File: rtl/seg_if.sv
// Value/flag inputs and segment/anode outputs of the scan driver.
interface seg_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] num;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   flash;
    logic [DIGITS-1:0]   blank;
    logic [7:0]          display;
    logic [DIGITS-1:0]   an;
    logic                frame_tick;

    modport master (output num, dp, flash, blank, input display, an, frame_tick);
    modport slave  (input num, dp, flash, blank, output display, an, frame_tick);
endinterface

// File: rtl/seg_decode.sv
// Combinational hex nibble + decimal point to active-low segment byte.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = {SEG_GLYPH[nib], ~dp};
endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with dead-time gaps, blink and blank.
// Optional leading-zero suppression when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYCLES = 500,
    parameter int BLINK_DIV  = 50000000
) (
    input  logic  clk,
    input  logic  rst_n,
    seg_if.slave  bus
);
    localparam int CNT_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDX_W = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(DIGITS - 1);

    slot_state_e       state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        disp_q, disp_d;
    logic              tick_q, tick_d;
    logic [BLK_W-1:0]  blk_cnt;
    logic              blink_phase;

    logic [3:0]        cur_nib;
    logic [7:0]        cur_seg;
    logic [DIGITS-1:0] lz_mask;
    logic              dark;

    assign cur_nib = bus.num[{idx, 2'b00} +: 4];

    seg_decode u_dec (.nib(cur_nib), .dp(bus.dp[idx]), .seg(cur_seg));

`ifdef SEG_LZ_BLANK_EN
    // Walk down from the leftmost digit; a digit is suppressed while every
    // nibble from it upward is zero. Digit 0 is never suppressed.
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run        = run & (bus.num[4*i +: 4] == 4'd0);
            lz_mask[i] = run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign dark = bus.blank[idx] | (bus.flash[idx] & blink_phase) | lz_mask[idx];

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        idx_d   = idx;
        an_d    = an_q;
        disp_d  = disp_q;
        tick_d  = 1'b0;
        case (state)
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = SHOW;
                    if (dark) begin
                        an_d   = '1;
                        disp_d = SEG_OFF;
                    end else begin
                        an_d   = ~(DIGITS'(1) << idx);
                        disp_d = cur_seg;
                    end
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    idx_d   = (idx == '0) ? IDX_TOP : idx - 1'b1;
                    an_d    = '1;
                    disp_d  = SEG_OFF;
                    tick_d  = (idx == '0);
                end
            end
            default: state_d = GAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= GAP;
            cnt    <= '0;
            idx    <= IDX_TOP;
            an_q   <= '1;
            disp_q <= SEG_OFF;
            tick_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            idx    <= idx_d;
            an_q   <= an_d;
            disp_q <= disp_d;
            tick_q <= tick_d;
        end
    end

    // Blink runs freely, unrelated to slot timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (blk_cnt == BLK_LAST) begin
            blk_cnt     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blk_cnt     <= blk_cnt + 1'b1;
        end
    end

    assign bus.an         = an_q;
    assign bus.display    = disp_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (DIGITS=4, SCAN_DIV=8, GAP_CYCLES=2, BLINK_DIV=64).
module tb_seg_scan_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg_if #(.DIGITS(4)) bus ();

    seg_scan_driver #(
        .DIGITS(4), .SCAN_DIV(8), .GAP_CYCLES(2), .BLINK_DIV(64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0]     num;
        logic [3:0]      dp;
        logic [3:0]      flash;
        logic [3:0]      blank;
        logic [3:0][7:0] seg;   // lit segment byte per digit
        logic [3:0]      lz;    // digits dark under leading-zero suppression
        int              cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset an", bus.an, 4'hF);
        chk("reset display", bus.display, 8'hFF);
        chk("reset frame_tick", bus.frame_tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [3:0] mask, exp_an;
        logic [7:0] exp_d;
        logic       ph, lit;
        int         k, d, m;
`ifdef SEG_LZ_BLANK_EN
        mask = v.lz;
`else
        mask = 4'b0000;
`endif
        bus.num = v.num; bus.dp = v.dp; bus.flash = v.flash; bus.blank = v.blank;
        apply_reset();
        for (int n = 1; n <= v.cycles; n++) begin
            @(negedge clk);
            if (n % 8 == 0 || n % 8 == 1) begin
                exp_an = 4'hF;
                exp_d  = 8'hFF;
            end else begin
                k   = (n - 2) / 8;
                d   = 3 - (k % 4);
                m   = 2 + 8 * k;                // posedge that sampled this slot
                ph  = (((m - 1) / 64) % 2) != 0;
                lit = !(v.blank[d] || (v.flash[d] && ph) || mask[d]);
                exp_an = lit ? ~(4'b0001 << d) : 4'hF;
                exp_d  = lit ? v.seg[d] : 8'hFF;
            end
            chk($sformatf("v%0d an n=%0d", id, n), bus.an, exp_an);
            chk($sformatf("v%0d display n=%0d", id, n), bus.display, exp_d);
            chk($sformatf("v%0d frame_tick n=%0d", id, n), bus.frame_tick, (n % 32 == 0));
        end
    endtask

    initial begin
        bus.num = '0; bus.dp = '0; bus.flash = '0; bus.blank = '0;

        vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, 4'b0000, 32'h9F251171, 4'b0000, 40};
        vecs[1] = '{16'h12AF, 4'b1000, 4'b0100, 4'b0001, 32'h9E251171, 4'b0000, 160};
        vecs[2] = '{16'h0030, 4'b0000, 4'b0000, 4'b0000, 32'h03030D03, 4'b1100, 40};
        vecs[3] = '{16'h0000, 4'b0000, 4'b0000, 4'b0000, 32'h03030303, 4'b1110, 40};
        vecs[4] = '{16'h8E5B, 4'b0101, 4'b0000, 4'b0000, 32'h016049C0, 4'b0000, 40};
        vecs[5] = '{16'h0C6D, 4'b0000, 4'b0000, 4'b0000, 32'h03634185, 4'b1000, 40};

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Mid-SHOW value change: current slot holds, later slots use new value
        bus.num = 16'h1234; bus.dp = '0; bus.flash = '0; bus.blank = '0;
        apply_reset();
        for (int n = 1; n <= 12; n++) @(negedge clk);
        chk("mid an d2", bus.an, 4'b1011);
        chk("mid display d2 before", bus.display, 8'h25);
        bus.num = 16'h5678;
        @(negedge clk);
        chk("mid display d2 held", bus.display, 8'h25);
        for (int n = 14; n <= 18; n++) @(negedge clk);
        chk("mid an d1", bus.an, 4'b1101);
        chk("mid display d1 new", bus.display, 8'h1F);
        for (int n = 19; n <= 26; n++) @(negedge clk);
        chk("mid an d0", bus.an, 4'b1110);
        chk("mid display d0 new", bus.display, 8'h01);

        // Asynchronous reset between edges during SHOW
        bus.num = 16'h1234;
        apply_reset();
        for (int n = 1; n <= 4; n++) @(negedge clk);
        chk("async pre an", bus.an, 4'b0111);
        chk("async pre display", bus.display, 8'h9F);
        #2 rst_n = 1'b0;
        #1;
        chk("async an", bus.an, 4'hF);
        chk("async display", bus.display, 8'hFF);
        chk("async frame_tick", bus.frame_tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-async gap1 an", bus.an, 4'hF);
        @(negedge clk);
        chk("post-async show an", bus.an, 4'b0111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
